// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Main control unit of a multicycle MIPS-style processor. The state register
//   and the state-derived control flags are registered together. Only ir_write,
//   pc_en and illegal_op combine those flags with live inputs (mem_ready,
//   zero_flag, opcode/funct). Asserting rst_n clears every enable at once.
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcode, funct         IR[31:26] / IR[5:0] of the latched instruction
//   zero_flag, mem_ready  ALU zero flag / memory completion handshake
//   pc_en, pc_src         PC load enable and PC source select
//   iord, mem_read, mem_write, ir_write       memory / IR control
//   reg_dst, mem_to_reg, reg_write            register-file control
//   alusrcA, alusrcB, alu_control             ALU operand / operation select
//   illegal_op            pulse in DECODE on an unsupported instruction
//   instr_count           retired-instruction counter (wraps)
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alusrcA,
  output logic [1:0]       alusrcB,
  output logic [3:0]       alu_control,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_FETCH   = 4'd1,  S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,  S_MEMRD   = 4'd4,  S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,  S_EXEC    = 4'd7,  S_ALUWB   = 4'd8,
    S_ADDI_EX = 4'd9,  S_ADDI_WB = 4'd10, S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  // fetch/decode/pc_write/pc_write_cond are state flags that get qualified
  // by live inputs before they reach the ports.
  typedef struct packed {
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       decode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [3:0] alu_control;
  } ctl_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    logic ok;
    case (fn)
      6'h20, 6'h22, 6'h24, 6'h25: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    if (op == OP_RTYPE) begin
      ok = funct_legal(fn);
    end else begin
      ok = (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J)  || (op == OP_ADDI);
    end
    return ok;
  endfunction

  function automatic logic [3:0] alu_for_funct(input logic [5:0] fn);
    logic [3:0] a;
    case (fn)
      6'h22:   a = ALU_SUB;
      6'h24:   a = ALU_AND;
      6'h25:   a = ALU_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Control word for a state; funct only matters for EXEC.
  function automatic ctl_t decode_ctl(input state_t st, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    case (st)
      S_IDLE:    begin end
      S_FETCH:   begin c.mem_read = 1'b1; c.fetch = 1'b1; c.alusrc_b = 2'b01; end
      S_DECODE:  begin c.decode = 1'b1; c.alusrc_b = 2'b10; end
      S_MEMADR:  begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXEC:    begin c.alusrc_a = 1'b1; c.alu_control = alu_for_funct(fn); end
      S_ALUWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_ADDI_EX: begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; end
      S_ADDI_WB: begin c.reg_write = 1'b1; end
      S_BRANCH:  begin
        c.alusrc_a = 1'b1; c.alu_control = ALU_SUB;
        c.pc_write_cond = 1'b1; c.pc_src = 2'b01;
      end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             retire_s;
  ctl_t             ctl_r;
  ctl_t             ctl_s;
  logic             state_ok_s;
  logic [CNT_W-1:0] count_r;

  // Next-state and retire decision.
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      S_IDLE:   state_next_s = S_FETCH;
      S_FETCH:  begin
        if (mem_ready) state_next_s = S_DECODE;
        else           state_next_s = S_FETCH;
      end
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)             state_next_s = S_MEMADR;
        else if (opcode == OP_RTYPE && funct_legal(funct))  state_next_s = S_EXEC;
        else if (opcode == OP_BEQ)                          state_next_s = S_BRANCH;
        else if (opcode == OP_J)                            state_next_s = S_JUMP;
        else if (opcode == OP_ADDI)                         state_next_s = S_ADDI_EX;
        else                                                state_next_s = S_FETCH;
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_next_s = S_MEMRD;
        else if (opcode == OP_SW) state_next_s = S_MEMWR;
        else                      state_next_s = S_FETCH;
      end
      S_MEMRD:  begin
        if (mem_ready) state_next_s = S_MEMWB;
        else           state_next_s = S_MEMRD;
      end
      S_MEMWR:  begin
        if (mem_ready) begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = S_MEMWR;
        end
      end
      S_EXEC:    state_next_s = S_ALUWB;
      S_ADDI_EX: state_next_s = S_ADDI_WB;
      S_MEMWB, S_ALUWB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      default:   state_next_s = S_FETCH;
    endcase
  end

  // State, registered control word and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ctl_r   <= decode_ctl(S_IDLE, 6'h00);
      count_r <= '0;
    end else begin
      state_r <= state_next_s;
      ctl_r   <= decode_ctl(state_next_s, funct);
      if (retire_s) count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else          count_r <= count_r;
    end
  end

  // A corrupted state encoding silences every output until FETCH is reloaded.
  always_comb begin
    state_ok_s = (state_r <= S_JUMP);
    if (state_ok_s) ctl_s = ctl_r;
    else            ctl_s = '0;
  end

  assign pc_en       = (ctl_s.fetch & mem_ready) | ctl_s.pc_write |
                       (ctl_s.pc_write_cond & zero_flag);
  assign ir_write    = ctl_s.fetch & mem_ready;
  assign illegal_op  = ctl_s.decode & ~instr_legal(opcode, funct);
  assign pc_src      = ctl_s.pc_src;
  assign iord        = ctl_s.iord;
  assign mem_read    = ctl_s.mem_read;
  assign mem_write   = ctl_s.mem_write;
  assign reg_dst     = ctl_s.reg_dst;
  assign mem_to_reg  = ctl_s.mem_to_reg;
  assign reg_write   = ctl_s.reg_write;
  assign alusrcA     = ctl_s.alusrc_a;
  assign alusrcB     = ctl_s.alusrc_b;
  assign alu_control = ctl_s.alu_control;
  assign instr_count = count_r;

endmodule
